// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - iterative signed multiply/divide unit owning the HI/LO registers
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             start,        // one-cycle request, sampled on the rising edge
    input  logic [2:0]       op,           // 0 MULT 1 MADD 2 MSUB 3 DIV 4 MTHI 5 MTLO
    input  logic [WIDTH-1:0] rs_data,      // multiplicand / dividend / MTHI-MTLO data
    input  logic [WIDTH-1:0] rt_data,      // multiplier / divisor
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_MADD = 3'd1;
    localparam logic [2:0] OP_MSUB = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]         op_q;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   b_mag;
    // Shared work register: for multiply it is {partial product, remaining multiplier bits},
    // for divide it is {partial remainder, dividend bits becoming quotient bits}.
    logic [2*WIDTH-1:0] work;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               div_zero_req;
    logic               iter_req;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] mac_result;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign accept       = start && (state == S_IDLE) && (op <= OP_MTLO);
    assign div_zero_req = (op == OP_DIV) && (rt_data == '0);
    assign iter_req     = accept && (op <= OP_DIV) && !div_zero_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (iter_req) state_next = S_CALC;
            S_CALC:  if (cnt == LAST) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One iteration of shift-add multiply and of restoring division.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, b_mag} : '0);
        mul_next  = {mul_sum, work[WIDTH-1:1]};
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        // The partial remainder is always below the divisor, so div_shift never
        // carries into its top bit and dropping it on restore loses nothing.
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and accumulate for the FIX cycle.
    always_comb begin
        prod_signed = (sign_a ^ sign_b) ? -work : work;
        mac_result  = prod_signed;
        case (op_q)
            OP_MADD: mac_result = {hi, lo} + prod_signed;
            OP_MSUB: mac_result = {hi, lo} - prod_signed;
            default: mac_result = prod_signed;
        endcase
        quo_fix = (sign_a ^ sign_b) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_fix = sign_a ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            op_q        <= OP_MULT;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_mag       <= '0;
            work        <= '0;
            cnt         <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        sign_a <= rs_data[WIDTH-1];
                        sign_b <= rt_data[WIDTH-1];
                        b_mag  <= mag(rt_data);
                        work   <= {{WIDTH{1'b0}}, mag(rs_data)};
                        cnt    <= '0;
                        if (op == OP_MTHI) begin
                            hi   <= rs_data;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= rs_data;
                            done <= 1'b1;
                        end else if (div_zero_req) begin
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    work <= (op_q == OP_DIV) ? div_next : mul_next;
                    cnt  <= cnt + 1'b1;
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (op_q == OP_DIV) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= mac_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - randomized self-checking bench for muldiv_hilo_unit
module tb_muldiv_hilo_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int           n_chk = 0;
    int           n_bad = 0;
    logic [63:0]  m_hilo = '0;

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural meaning of each op, in plain 64-bit signed arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl,
                                          output bit dz);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        dz = 1'b0;
        case (o)
            3'd0: return p;
            3'd1: return hl + p;
            3'd2: return hl - p;
            3'd3: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    return hl;
                end
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: return {a, hl[31:0]};
            3'd5: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op, optionally pokes a stray start at cycle 'poke' while busy,
    // and checks latency, busy length, flags and the resulting HI/LO.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input bit b2b);
        int          k;
        int          bc;
        bit          exp_dz;
        bit          iter;
        logic [63:0] exp_hilo;
        if (!b2b) begin
            @(negedge clk);
            check("idle_done", 64'(done), 64'd0);
        end
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = 3'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        exp_hilo = model(o, a, b, m_hilo, exp_dz);
        iter = (o <= 3'd3) && !exp_dz;
        k  = 1;
        bc = 0;
        while (!done && k < 60) begin
            if (busy) bc++;
            if (k == 16) check("hilo_hold", {hi, lo}, m_hilo);
            start = (k == poke);
            if (k == poke) begin
                op      = 3'($urandom);
                rs_data = $urandom;
                rt_data = $urandom;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("latency", 64'(k), iter ? 64'(W + 2) : 64'd1);
        check("busy_cycles", 64'(bc), iter ? 64'(W + 1) : 64'd0);
        check("busy_at_done", 64'(busy), 64'd0);
        check("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
        check("hilo", {hi, lo}, exp_hilo);
        m_hilo = exp_hilo;
    endtask

    initial begin
        bit seen;
        #1 reset = 1'b0;
        #11;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0005, 0, 1'b0);
        check("tp_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
        check("tp_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        check("tp_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd4, 32'h0000_0000, 32'h0, 0, 1'b0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'h1, 32'h1, 0, 1'b0);
        check("tp_madd", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op(3'd2, 32'h2, 32'h3, 0, 1'b0);
        check("tp_msub", {hi, lo}, 64'h0000_0000_FFFF_FFFA);
        run_op(3'd4, 32'h0000_1234, 32'h0, 0, 1'b0);
        run_op(3'd3, 32'h5, 32'h0, 0, 1'b0);
        check("tp_dz_hi", 64'(hi), 64'h1234);

        run_op(3'd0, $urandom, $urandom, 10, 1'b0);
        run_op(3'd3, $urandom, 32'h0000_0007, 0, 1'b1);

        // Reset in the middle of a multiply.
        run_op(3'd5, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_data = 32'd7; rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        m_hilo = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);

        // Illegal opcodes.
        start = 1'b1; op = 3'd6; rs_data = $urandom; rt_data = $urandom;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || div_by_zero) seen = 1'b1;
        end
        check("illegal_quiet", 64'(seen), 64'd0);
        check("illegal_hilo", {hi, lo}, m_hilo);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 3'($urandom_range(0, 5));
            a = pick();
            b = pick();
            if (o == 3'd3 && $urandom_range(0, 4) == 0) b = 32'd0;
            run_op(o, a, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0,
                   $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Iterative signed multiply/divide unit that owns the architectural HI/LO registers of the multi-cycle MIPS datapath. It sits downstream of the microprogrammed control unit, executing mult, madd, msub, div, mthi and mtlo on register-file operands. It also exposes HI/LO for mfhi/mflo and a busy flag the sequencer polls before issuing the next HI/LO instruction.

## Interface
- WIDTH, 32, operand and HI/LO register width; the iteration count equals WIDTH.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle operation request; sampled on the rising edge.
- op  in  3  operation code: 0 MULT, 1 MADD, 2 MSUB, 3 DIV, 4 MTHI, 5 MTLO; 6 and 7 are illegal.
- rs_data  in  WIDTH  operand A: multiplicand, dividend, or write data for MTHI/MTLO.
- rt_data  in  WIDTH  operand B: multiplier or divisor.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse when an accepted operation completes.
- div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV with rt_data == 0.

## Operation
- FSM states:
  - IDLE: the only state that accepts start.
  - CALC: WIDTH iterations.
  - FIX: sign correction, accumulate, HI/LO write.
- A request is accepted when start=1, state=IDLE and op ≤ 5. On acceptance, rs_data, rt_data and op are latched. Later input changes have no effect.
- start while busy=1 is ignored: no queueing, no side effects.
- Illegal op (6, 7) is ignored: no done, no state change.
- MTHI/MTLO:
  - HI (or LO) ← rs_data on the accepting edge; the other register is unchanged.
  - done=1 for the next cycle; busy stays 0.
- MULT/MADD/MSUB:
  - Operands are converted to magnitudes and multiplied by shift-add, one bit per CALC cycle.
  - FIX negates the 2N-bit product if the operand signs differ, giving P.
  - MULT: {HI,LO} ← P. MADD: {HI,LO} ← {HI,LO} + P. MSUB: {HI,LO} ← {HI,LO} − P. All arithmetic is modulo 2^(2·WIDTH).
- DIV:
  - Magnitude restoring division, one quotient bit per CALC cycle.
  - FIX produces a quotient truncated toward zero and a remainder carrying the dividend's sign: LO ← quotient, HI ← remainder.
  - Overflow case −2^(N−1) / −1 gives LO=0x80000000, HI=0 (wrap, no flag).
- DIV with rt_data==0:
  - CALC is skipped and HI/LO are unchanged.
  - done=1 and div_by_zero=1 for the cycle after the accepting edge; busy stays 0.
- HI/LO change only in FIX, on an MTHI/MTLO accept, or on reset.

## Timing
- Reset (asynchronous, while reset=0): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Reset mid-operation aborts it, clears HI/LO, and produces no done.
  - First accept is possible on the first rising edge after reset deasserts.
- Iterative ops accepted on edge E0:
  - busy=1 from after E0 through the cycle before E(N+1).
  - CALC iterates on edges E1..EN; FIX occurs on E(N+1).
  - After E(N+1): HI/LO hold the result, done=1 for exactly one cycle, busy=0, state=IDLE.
  - Total latency is N+1 cycles (33 for WIDTH=32).
- A new start may coincide with the done cycle; it is accepted on that edge (back-to-back throughput of N+1 cycles).
- MTHI/MTLO and divide-by-zero: latency 1 cycle, with done on the cycle after the accepting edge.
- busy and done are never both 1.
- hi, lo, busy, done and div_by_zero are all registered outputs; there is no combinational path from the inputs.

## Test plan
- Reset, then MULT rs=0xFFFFFFFF, rt=0x00000005 → after 33 cycles, done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFFB; busy high for exactly 33 cycles.
- DIV rs=0xFFFFFFF9 (−7), rt=0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0, MTLO 0xFFFFFFFF, MADD rs=1, rt=1 → hi=0x00000001, lo=0. Then MSUB rs=2, rt=3 → hi=0x00000000, lo=0xFFFFFFFA.
- MTHI 0x1234 then DIV rs=5, rt=0 → the next cycle shows done=1 and div_by_zero=1, hi=0x1234 unchanged, busy never asserted.
- MULT accepted; assert start with op=DIV at cycle 10 → ignored, and the MULT result is correct. Then start in the done cycle → accepted, busy=1 on the following cycle.
- MULT 7×9 accepted; pull reset low at cycle 15 (between edges) → outputs clear immediately and no done pulse follows. op=6 with start → no response.
